datapath_seq: RTL and testbench
===============================

# datapath_seq

Parametrised, self-sequencing successor to the lab datapath. It keeps the register file, A/B operand registers, shifter, ALU, C result register and status flags, and adds a built-in FSM. A single `start` pulse runs a complete read/execute/write-back operation and ends with a `done` pulse, so the controller only issues operation descriptors. The block sits between the instruction decoder/controller and memory, as the CPU's execution core.

## Interface
- `WIDTH`, 16, datapath and register width (≥ 8)
- `NREGS`, 8, register count, power of two ≥ 2
- `PC_W`, 8, program-counter width (≤ WIDTH)
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  operation request, sampled only while `ready`=1
- `ready`  out  1  high in IDLE; accepts `start`
- `done`  out  1  one-cycle pulse in the write-back cycle
- `op`  in  2  ALU op: ADD, SUB, AND, MVN (~B)
- `rn`, `rm`, `rd`  in  $clog2(NREGS) each  A source, B source, destination
- `shift`  in  2  B shift: none, LSL1, LSR1 (logical), ASR1
- `asel_zero`  in  1  force A operand to 0
- `bsel_imm`  in  1  B operand = `sximm5` (bypasses shifter)
- `wsrc`  in  2  write-back source: C, PC, IMM8, MDATA
- `wb_en`  in  1  write R[rd] at write-back
- `flags_en`  in  1  update flags at EXEC
- `sximm5`, `sximm8`, `mdata`  in  WIDTH each  pre-sign-extended immediates, memory data
- `pc`  in  PC_W  program counter, zero-extended on write
- `result`  out  WIDTH  C register
- `flags`  out  3  {N,V,Z}

## Operation
- All descriptor inputs are latched on the accept edge (`start & ready`). Later changes to them are ignored until the next accept.
- FSM states: IDLE, RD_A, RD_B, EXEC, WB.
  - wsrc=C path: IDLE→RD_A→RD_B→EXEC→WB→IDLE.
  - Other wsrc values: IDLE→WB→IDLE. A, B, C and flags are untouched.
- RD_A edge: A←R[rn]. RD_B edge: B←R[rm].
- EXEC edge: C←ALU(Ain,Bin). If `flags_en`=1, flags←{N,V,Z}.
- WB edge: if `wb_en`=1, R[rd]←selected source.
- Arithmetic is modulo 2^WIDTH.
  - Z = (ALU out == 0). N = ALU out MSB.
  - V for ADD: A and B signs equal and the result sign differs.
  - V for SUB: A and B signs differ and the result sign differs from A.
  - V = 0 for AND and MVN.
- Shift applies to B before the bsel mux. ASR replicates the MSB.
- `start` while busy is ignored; there is no queueing.
- Reset clears R0..R(NREGS-1), A, B, C and flags, and forces IDLE.
- Reset mid-operation aborts the operation: no write-back and no `done`.
- After reset: `ready`=1, `done`=0, `result`=0, `flags`=000.

## Timing
- Accept at edge 0.
  - ALU path: `done` is high in the cycle after edge 3; the write occurs at edge 4.
  - Direct path: `done` is high in the cycle after edge 0; the write occurs at edge 1.
- `ready` is low from accept until the WB edge, so `start` can next be accepted at the WB edge+1.
- `result` and `flags` change only at EXEC edges and are stable otherwise.
- rd==rn or rd==rm needs no forwarding, because reads precede write-back within an operation. The next operation reads the updated value.
- Register-file reads are combinational and sampled at the RD edges. The write is synchronous.

## Structure
- Package `datapath_pkg` holds:
  - enums `alu_op_e`, `shift_e`, `wsrc_e`, `state_e`
  - flag index constants `FLAG_N`, `FLAG_V`, `FLAG_Z`
- Sub-module `regfile_p` (WIDTH, NREGS): async reset, one synchronous write port, one combinational read port.
- Shifter and ALU are inline combinational logic.

## Test plan
All scenarios use WIDTH=16 unless stated.
- Reset, then wsrc=IMM8, sximm8=0x0007, rd=0, wb_en=1, start → `done` one cycle after accept; R0=0x0007; `result`=0, `flags`=000.
- R0=7, R1=2; ADD rn=0 rm=1 rd=2, shift=LSL1, flags_en=1 → `done` at accept+4; R2=0x000B; flags=000.
- SUB R0-R0, wb_en=0, flags_en=1 → flags Z=1, `result`=0, no register change. Then ADD 0x7FFF+0x0001 → `result`=0x8000, N=1, V=1.
- Reset asserted during EXEC → `result`/`flags`/`done` go to 0 immediately and `ready`=1; after release, R[rd] still holds 0.
- `start` pulsed during RD_B of an active op → exactly one `done`; the second descriptor has no effect.
- WIDTH=32, NREGS=16, PC_W=8: wsrc=PC, pc=0xFF, rd=15 → R15=0x000000FF. With R0=0x80000000, asel_zero=1, ADD, shift=ASR1 → `result`=0xC0000000, N=1.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types and constants for the self-sequencing datapath.
// Operation, shift, write-back source and FSM state encodings live here.
package datapath_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_MVN = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'd0,
        SH_LSL1 = 2'd1,
        SH_LSR1 = 2'd2,
        SH_ASR1 = 2'd3
    } shift_e;

    typedef enum logic [1:0] {
        WS_C     = 2'd0,
        WS_PC    = 2'd1,
        WS_IMM8  = 2'd2,
        WS_MDATA = 2'd3
    } wsrc_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    // Bit positions inside the {N,V,Z} flags vector.
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/datapath_seq_regfile.sv
// Parametrised register file: one synchronous write port, one combinational
// read port, all entries cleared by asynchronous reset.
module regfile_p #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(NREGS)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [NREGS];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/datapath_seq.sv
// Execution core: register file, A/B/C registers, shifter, ALU and flags,
// sequenced by an internal FSM from a single start pulse per operation.
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8,
    parameter int unsigned PC_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     ready,
    output logic                     done,
    input  logic [1:0]               op,
    input  logic [$clog2(NREGS)-1:0] rn,
    input  logic [$clog2(NREGS)-1:0] rm,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [1:0]               shift,
    input  logic                     asel_zero,
    input  logic                     bsel_imm,
    input  logic [1:0]               wsrc,
    input  logic                     wb_en,
    input  logic                     flags_en,
    input  logic [WIDTH-1:0]         sximm5,
    input  logic [WIDTH-1:0]         sximm8,
    input  logic [WIDTH-1:0]         mdata,
    input  logic [PC_W-1:0]          pc,
    output logic [WIDTH-1:0]         result,
    output logic [2:0]               flags
);

    localparam int unsigned AW = $clog2(NREGS);

    state_e r_state;
    state_e w_next;

    // Latched operation descriptor
    alu_op_e          r_op;
    shift_e           r_shift;
    wsrc_e            r_wsrc;
    logic [AW-1:0]    r_rn;
    logic [AW-1:0]    r_rm;
    logic [AW-1:0]    r_rd;
    logic             r_asel_zero;
    logic             r_bsel_imm;
    logic             r_wb_en;
    logic             r_flags_en;
    logic [WIDTH-1:0] r_imm5;
    logic [WIDTH-1:0] r_imm8;
    logic [WIDTH-1:0] r_mdata;
    logic [PC_W-1:0]  r_pc;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [2:0]       r_flags;

    logic             w_accept;
    logic             w_wr_en;
    logic [AW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] w_bsh;
    logic [WIDTH-1:0] w_ain;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_alu;
    logic             w_ovf;
    logic [WIDTH-1:0] w_wdata;

    assign w_accept = start && (r_state == ST_IDLE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (wsrc_e'(wsrc) == WS_C) ? ST_RD_A : ST_WB;
                end
            end
            ST_RD_A: w_next = ST_RD_B;
            ST_RD_B: w_next = ST_EXEC;
            ST_EXEC: w_next = ST_WB;
            ST_WB:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready     = (r_state == ST_IDLE);
        done      = (r_state == ST_WB);
        w_wr_en   = (r_state == ST_WB) && r_wb_en;
        w_rd_addr = (r_state == ST_RD_B) ? r_rm : r_rn;
    end

    // ---------------- Descriptor latch ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op        <= ALU_ADD;
            r_shift     <= SH_NONE;
            r_wsrc      <= WS_C;
            r_rn        <= '0;
            r_rm        <= '0;
            r_rd        <= '0;
            r_asel_zero <= 1'b0;
            r_bsel_imm  <= 1'b0;
            r_wb_en     <= 1'b0;
            r_flags_en  <= 1'b0;
            r_imm5      <= '0;
            r_imm8      <= '0;
            r_mdata     <= '0;
            r_pc        <= '0;
        end else if (w_accept) begin
            r_op        <= alu_op_e'(op);
            r_shift     <= shift_e'(shift);
            r_wsrc      <= wsrc_e'(wsrc);
            r_rn        <= rn;
            r_rm        <= rm;
            r_rd        <= rd;
            r_asel_zero <= asel_zero;
            r_bsel_imm  <= bsel_imm;
            r_wb_en     <= wb_en;
            r_flags_en  <= flags_en;
            r_imm5      <= sximm5;
            r_imm8      <= sximm8;
            r_mdata     <= mdata;
            r_pc        <= pc;
        end
    end

    // ---------------- Register file ----------------
    regfile_p #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .i_clk   (clk),
        .i_reset (reset),
        .i_we    (w_wr_en),
        .i_waddr (r_rd),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    // ---------------- Shifter and operand select ----------------
    always_comb begin
        w_bsh = r_b;
        case (r_shift)
            SH_NONE: w_bsh = r_b;
            SH_LSL1: w_bsh = {r_b[WIDTH-2:0], 1'b0};
            SH_LSR1: w_bsh = {1'b0, r_b[WIDTH-1:1]};
            SH_ASR1: w_bsh = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
            default: w_bsh = r_b;
        endcase
    end

    assign w_ain = r_asel_zero ? '0 : r_a;
    assign w_bin = r_bsel_imm ? r_imm5 : w_bsh;

    // ---------------- ALU ----------------
    always_comb begin
        w_alu = '0;
        w_ovf = 1'b0;
        case (r_op)
            ALU_ADD: begin
                w_alu = w_ain + w_bin;
                w_ovf = (w_ain[WIDTH-1] == w_bin[WIDTH-1]) &&
                        (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
            end
            ALU_SUB: begin
                w_alu = w_ain - w_bin;
                w_ovf = (w_ain[WIDTH-1] != w_bin[WIDTH-1]) &&
                        (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
            end
            ALU_AND: w_alu = w_ain & w_bin;
            ALU_MVN: w_alu = ~w_bin;
            default: w_alu = '0;
        endcase
    end

    // ---------------- Write-back source ----------------
    always_comb begin
        w_wdata = r_c;
        case (r_wsrc)
            WS_C:     w_wdata = r_c;
            WS_PC:    w_wdata = WIDTH'(r_pc);
            WS_IMM8:  w_wdata = r_imm8;
            WS_MDATA: w_wdata = r_mdata;
            default:  w_wdata = r_c;
        endcase
    end

    // ---------------- A, B, C and flags ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_flags <= '0;
        end else begin
            if (r_state == ST_RD_A) begin
                r_a <= w_rdata;
            end
            if (r_state == ST_RD_B) begin
                r_b <= w_rdata;
            end
            if (r_state == ST_EXEC) begin
                r_c <= w_alu;
                if (r_flags_en) begin
                    r_flags[FLAG_N] <= w_alu[WIDTH-1];
                    r_flags[FLAG_V] <= w_ovf;
                    r_flags[FLAG_Z] <= (w_alu == '0);
                end
            end
        end
    end

    assign result = r_c;
    assign flags  = r_flags;

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq: table-driven operations on a 16-bit
// instance, hand-written busy/reset sequences, and a 32-bit/16-register instance.
module tb_datapath_seq;
    import datapath_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  shift;
        logic [1:0]  wsrc;
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [2:0]  rd;
        logic        asel;
        logic        bsel;
        logic        wb;
        logic        fe;
        logic [15:0] imm5;
        logic [15:0] imm8;
        logic [15:0] mdata;
        logic [7:0]  pc;
        logic [15:0] eres;
        logic [2:0]  eflg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 16-bit instance ----------------
    logic        rst16, st16, rdy16, dn16;
    logic [1:0]  op16, sh16, ws16;
    logic [2:0]  rn16, rm16, rd16;
    logic        asel16, bsel16, wb16, fe16;
    logic [15:0] imm5_16, imm8_16, md16, res16;
    logic [7:0]  pc16;
    logic [2:0]  flg16;

    datapath_seq #(.WIDTH(16), .NREGS(8), .PC_W(8)) u_dut16 (
        .clk(clk), .reset(rst16), .start(st16), .ready(rdy16), .done(dn16),
        .op(op16), .rn(rn16), .rm(rm16), .rd(rd16), .shift(sh16),
        .asel_zero(asel16), .bsel_imm(bsel16), .wsrc(ws16), .wb_en(wb16),
        .flags_en(fe16), .sximm5(imm5_16), .sximm8(imm8_16), .mdata(md16),
        .pc(pc16), .result(res16), .flags(flg16)
    );

    // ---------------- 32-bit / 16-register instance ----------------
    logic        rst32, st32, rdy32, dn32;
    logic [1:0]  op32, sh32, ws32;
    logic [3:0]  rn32, rm32, rd32;
    logic        asel32, bsel32, wb32, fe32;
    logic [31:0] imm5_32, imm8_32, md32, res32;
    logic [7:0]  pc32;
    logic [2:0]  flg32;

    datapath_seq #(.WIDTH(32), .NREGS(16), .PC_W(8)) u_dut32 (
        .clk(clk), .reset(rst32), .start(st32), .ready(rdy32), .done(dn32),
        .op(op32), .rn(rn32), .rm(rm32), .rd(rd32), .shift(sh32),
        .asel_zero(asel32), .bsel_imm(bsel32), .wsrc(ws32), .wb_en(wb32),
        .flags_en(fe32), .sximm5(imm5_32), .sximm8(imm8_32), .mdata(md32),
        .pc(pc32), .result(res32), .flags(flg32)
    );

    exp_t q16[$];
    exp_t q32[$];
    exp_t e16, e32;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (dn16) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut16_unexpected_done: got done=1, expected done=0");
            end else begin
                e16 = q16.pop_front();
                chk("dut16_result", 32'(res16), e16.res);
                chk("dut16_flags", 32'(flg16), 32'(e16.flg));
            end
        end
        if (dn32) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut32_unexpected_done: got done=1, expected done=0");
            end else begin
                e32 = q32.pop_front();
                chk("dut32_result", res32, e32.res);
                chk("dut32_flags", 32'(flg32), 32'(e32.flg));
            end
        end
    end

    function automatic vec_t alu(input logic [1:0] op, input int rn, input int rm,
                                 input int rd, input logic [1:0] sh, input logic asel,
                                 input logic bsel, input logic [15:0] imm5,
                                 input logic wb, input logic fe,
                                 input logic [15:0] eres, input logic [2:0] eflg);
        vec_t v;
        v.op = op; v.shift = sh; v.wsrc = WS_C;
        v.rn = 3'(rn); v.rm = 3'(rm); v.rd = 3'(rd);
        v.asel = asel; v.bsel = bsel; v.wb = wb; v.fe = fe;
        v.imm5 = imm5; v.imm8 = 16'h0; v.mdata = 16'h0; v.pc = 8'h0;
        v.eres = eres; v.eflg = eflg;
        return v;
    endfunction

    function automatic vec_t dir(input logic [1:0] ws, input logic [15:0] val,
                                 input int rd, input logic wb,
                                 input logic [15:0] eres, input logic [2:0] eflg);
        vec_t v;
        v = alu(ALU_ADD, 0, 0, rd, SH_NONE, 1'b0, 1'b0, 16'h0, wb, 1'b0, eres, eflg);
        v.wsrc  = ws;
        v.imm8  = (ws == WS_IMM8)  ? val : 16'h0;
        v.mdata = (ws == WS_MDATA) ? val : 16'h0;
        v.pc    = (ws == WS_PC)    ? val[7:0] : 8'h0;
        return v;
    endfunction

    // Read R[r] out through C: R[r] + 0 with flags left alone.
    function automatic vec_t rb(input int r, input logic [15:0] eres, input logic [2:0] eflg);
        return alu(ALU_ADD, r, 0, 0, SH_NONE, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, eres, eflg);
    endfunction

    task automatic drive16(input vec_t v);
        op16 = v.op; sh16 = v.shift; ws16 = v.wsrc;
        rn16 = v.rn; rm16 = v.rm; rd16 = v.rd;
        asel16 = v.asel; bsel16 = v.bsel; wb16 = v.wb; fe16 = v.fe;
        imm5_16 = v.imm5; imm8_16 = v.imm8; md16 = v.mdata; pc16 = v.pc;
    endtask

    task automatic scramble16();
        op16 = 2'($urandom); sh16 = 2'($urandom); ws16 = 2'($urandom);
        rn16 = 3'($urandom); rm16 = 3'($urandom); rd16 = 3'($urandom);
        asel16 = 1'($urandom); bsel16 = 1'($urandom);
        wb16 = 1'($urandom); fe16 = 1'($urandom);
        imm5_16 = 16'($urandom); imm8_16 = 16'($urandom);
        md16 = 16'($urandom); pc16 = 8'($urandom);
    endtask

    task automatic go16(input vec_t v);
        int n;
        int lat;
        @(negedge clk);
        chk("dut16_ready_idle", 32'(rdy16), 32'd1);
        drive16(v);
        st16 = 1'b1;
        q16.push_back('{32'(v.eres), v.eflg});
        @(negedge clk);
        st16 = 1'b0;
        scramble16();
        chk("dut16_ready_busy", 32'(rdy16), 32'd0);
        n = 1;
        while (!dn16 && n < 12) begin
            @(negedge clk);
            n++;
        end
        lat = (v.wsrc == WS_C) ? 4 : 1;
        chk("dut16_done_latency", 32'(n), 32'(lat));
        @(negedge clk);
        chk("dut16_ready_after", 32'(rdy16), 32'd1);
    endtask

    task automatic go32(input logic [1:0] ws, input logic [1:0] op, input logic [3:0] rn,
                        input logic [3:0] rm, input logic [3:0] rd, input logic [1:0] sh,
                        input logic asel, input logic bsel, input logic wb, input logic fe,
                        input logic [31:0] imm8, input logic [7:0] pc,
                        input logic [31:0] eres, input logic [2:0] eflg);
        int n;
        @(negedge clk);
        ws32 = ws; op32 = op; rn32 = rn; rm32 = rm; rd32 = rd; sh32 = sh;
        asel32 = asel; bsel32 = bsel; wb32 = wb; fe32 = fe;
        imm5_32 = 32'h0; imm8_32 = imm8; md32 = 32'h0; pc32 = pc;
        st32 = 1'b1;
        q32.push_back('{eres, eflg});
        @(negedge clk);
        st32 = 1'b0;
        n = 1;
        while (!dn32 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("dut32_done_latency", 32'(n), (ws == WS_C) ? 32'd4 : 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int cnt;

        rst16 = 1'b1; rst32 = 1'b1; st16 = 1'b0; st32 = 1'b0;
        drive16(dir(WS_C, 16'h0, 0, 1'b0, 16'h0, 3'b000));
        op32 = '0; sh32 = '0; ws32 = '0; rn32 = '0; rm32 = '0; rd32 = '0;
        asel32 = 0; bsel32 = 0; wb32 = 0; fe32 = 0;
        imm5_32 = '0; imm8_32 = '0; md32 = '0; pc32 = '0;
        repeat (3) @(negedge clk);
        chk("rst16_ready", 32'(rdy16), 32'd1);
        chk("rst16_done", 32'(dn16), 32'd0);
        chk("rst16_result", 32'(res16), 32'd0);
        chk("rst16_flags", 32'(flg16), 32'd0);
        chk("rst32_ready", 32'(rdy32), 32'd1);
        chk("rst32_result", res32, 32'd0);
        rst16 = 1'b0; rst32 = 1'b0;

        // {descriptor, expected result, expected flags {N,V,Z}}
        tbl.push_back(dir(WS_IMM8,  16'h0007, 0, 1'b1, 16'h0000, 3'b000));
        tbl.push_back(dir(WS_IMM8,  16'h0002, 1, 1'b1, 16'h0000, 3'b000));
        tbl.push_back(alu(ALU_ADD, 0, 1, 2, SH_LSL1, 0, 0, 16'h0, 1, 1, 16'h000B, 3'b000));
        tbl.push_back(rb(2, 16'h000B, 3'b000));
        tbl.push_back(alu(ALU_SUB, 0, 0, 2, SH_NONE, 0, 0, 16'h0, 0, 1, 16'h0000, 3'b001));
        tbl.push_back(rb(2, 16'h000B, 3'b001));
        tbl.push_back(dir(WS_IMM8,  16'h7FFF, 3, 1'b1, 16'h000B, 3'b001));
        tbl.push_back(dir(WS_MDATA, 16'h0001, 4, 1'b1, 16'h000B, 3'b001));
        tbl.push_back(alu(ALU_ADD, 3, 4, 5, SH_NONE, 0, 0, 16'h0, 1, 1, 16'h8000, 3'b110));
        tbl.push_back(alu(ALU_SUB, 4, 3, 6, SH_NONE, 0, 0, 16'h0, 0, 1, 16'h8002, 3'b100));
        tbl.push_back(alu(ALU_SUB, 5, 4, 6, SH_NONE, 0, 0, 16'h0, 0, 1, 16'h7FFF, 3'b010));
        tbl.push_back(alu(ALU_AND, 3, 5, 6, SH_NONE, 0, 0, 16'h0, 0, 1, 16'h0000, 3'b001));
        tbl.push_back(alu(ALU_MVN, 0, 3, 7, SH_NONE, 0, 0, 16'h0, 1, 1, 16'h8000, 3'b100));
        tbl.push_back(alu(ALU_ADD, 0, 5, 6, SH_LSR1, 1, 0, 16'h0, 0, 1, 16'h4000, 3'b000));
        tbl.push_back(alu(ALU_ADD, 0, 5, 6, SH_ASR1, 1, 0, 16'h0, 0, 1, 16'hC000, 3'b100));
        tbl.push_back(dir(WS_PC,    16'h00AB, 6, 1'b1, 16'hC000, 3'b100));
        tbl.push_back(rb(6, 16'h00AB, 3'b100));
        tbl.push_back(rb(7, 16'h8000, 3'b100));
        tbl.push_back(alu(ALU_ADD, 0, 0, 6, SH_NONE, 0, 1, 16'hFFF0, 0, 1, 16'hFFF7, 3'b100));
        tbl.push_back(dir(WS_IMM8,  16'h1234, 0, 1'b0, 16'hFFF7, 3'b100));
        tbl.push_back(rb(0, 16'h0007, 3'b100));
        tbl.push_back(alu(ALU_ADD, 1, 1, 1, SH_NONE, 0, 0, 16'h0, 1, 0, 16'h0004, 3'b100));
        tbl.push_back(rb(1, 16'h0004, 3'b100));

        foreach (tbl[i]) go16(tbl[i]);

        // start during RD_B must be dropped: one done, R0 untouched
        @(negedge clk);
        drive16(alu(ALU_ADD, 0, 1, 3, SH_NONE, 0, 0, 16'h0, 1, 0, 16'h0, 3'b000));
        st16 = 1'b1;
        q16.push_back('{32'h0000_000B, 3'b100});
        @(negedge clk);
        st16 = 1'b0;
        @(negedge clk);
        drive16(dir(WS_IMM8, 16'h5555, 0, 1'b1, 16'h0, 3'b000));
        st16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (dn16) cnt++;
            @(negedge clk);
        end
        chk("busy_done_count", 32'(cnt), 32'd1);
        go16(rb(0, 16'h0007, 3'b100));
        go16(rb(3, 16'h000B, 3'b100));

        // Reset during EXEC aborts the write-back
        @(negedge clk);
        drive16(alu(ALU_ADD, 0, 0, 2, SH_NONE, 0, 0, 16'h0, 1, 1, 16'h0, 3'b000));
        st16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst16 = 1'b1;
        #1;
        chk("abort_result", 32'(res16), 32'd0);
        chk("abort_flags", 32'(flg16), 32'd0);
        chk("abort_done", 32'(dn16), 32'd0);
        chk("abort_ready", 32'(rdy16), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst16 = 1'b0;
        repeat (6) @(negedge clk);
        go16(rb(2, 16'h0000, 3'b000));

        // Wide instance: PC zero-extension and ASR1 of a negative operand
        go32(WS_PC,   ALU_ADD, 4'd0,  4'd0, 4'd15, SH_NONE, 0, 0, 1, 0, 32'h0, 8'hFF, 32'h0, 3'b000);
        go32(WS_C,    ALU_ADD, 4'd15, 4'd0, 4'd0,  SH_NONE, 0, 1, 0, 0, 32'h0, 8'h00, 32'h0000_00FF, 3'b000);
        go32(WS_IMM8, ALU_ADD, 4'd0,  4'd0, 4'd0,  SH_NONE, 0, 0, 1, 0, 32'h8000_0000, 8'h00, 32'h0000_00FF, 3'b000);
        go32(WS_C,    ALU_ADD, 4'd0,  4'd0, 4'd1,  SH_ASR1, 1, 0, 0, 1, 32'h0, 8'h00, 32'hC000_0000, 3'b100);

        repeat (4) @(negedge clk);
        chk("q16_drained", 32'(q16.size()), 32'd0);
        chk("q32_drained", 32'(q32.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
